// File: rtl/issue_queue_pkg.sv
// Shared types for the decode->execute issue queue: queued instruction entry,
// bypass request/response records and the default queue depth.
package issue_queue_pkg;

    localparam int IQ_DEPTH = 8;

    typedef logic [31:0] word_t;
    typedef logic [4:0]  reg_t;

    typedef struct packed {
        word_t pc;
        reg_t  ra1;
        logic  rd_ra1;
        reg_t  ra2;
        logic  rd_ra2;
        reg_t  dst;
        logic  wr_gpr;
        logic  is_mem;
        logic  rd_hilo;
        logic  wr_hilo;
        logic  rd_cp0;
        logic  wr_cp0;
        logic  is_branch;
        logic  is_trap;     // eret / syscall / break
    } issue_entry_t;

    typedef struct packed {
        reg_t ra1;
        logic rd_ra1;
        reg_t ra2;
        logic rd_ra2;
        logic rd_hilo;
        logic rd_cp0;
    } bypass_issue_t;

    typedef struct packed {
        logic  valid;
        word_t fwd;
    } bypass_output_t;

    function automatic bypass_issue_t to_bypass(input issue_entry_t e);
        bypass_issue_t b;
        b.ra1     = e.ra1;
        b.rd_ra1  = e.rd_ra1;
        b.ra2     = e.ra2;
        b.rd_ra2  = e.rd_ra2;
        b.rd_hilo = e.rd_hilo;
        b.rd_cp0  = e.rd_cp0;
        return b;
    endfunction

endpackage

// File: rtl/issue_pair_check.sv
// Decides whether the two oldest entries may issue together in the same cycle.
// Purely combinational; slot 0 is the older instruction.
module issue_pair_check
    import issue_queue_pkg::*;
(
    input  issue_entry_t i_slot0,
    input  issue_entry_t i_slot1,
    output logic         o_pair_ok
);

    logic w_raw;
    logic w_mem;
    logic w_hilo;
    logic w_cp0;
    logic w_branch;
    logic w_trap;
    logic w_unused;

    // r0 is hardwired zero, so a write to it never creates a dependency
    assign w_raw = i_slot0.wr_gpr && (i_slot0.dst != '0) &&
                   ((i_slot1.rd_ra1 && (i_slot1.ra1 == i_slot0.dst)) ||
                    (i_slot1.rd_ra2 && (i_slot1.ra2 == i_slot0.dst)));

    assign w_mem    = i_slot0.is_mem  & i_slot1.is_mem;
    assign w_hilo   = i_slot0.wr_hilo & i_slot1.wr_hilo;
    assign w_cp0    = i_slot0.wr_cp0  & i_slot1.rd_cp0;
    // a branch in slot 1 must wait so its delay slot issues alongside it
    assign w_branch = i_slot1.is_branch;
    assign w_trap   = i_slot0.is_trap;

    assign o_pair_ok = ~(w_raw | w_mem | w_hilo | w_cp0 | w_branch | w_trap);

    assign w_unused = ^{i_slot0, i_slot1};

endmodule

// File: rtl/issue_queue.sv
// Dual-issue in-order queue between decode and execute; head entry with ready operands reaches out_* one edge later.
// Accepts a pair only when two slots are free; ex_stall freezes issue and the out register, flush empties everything.
module issue_queue
    import issue_queue_pkg::*;
#(
    parameter int DEPTH = IQ_DEPTH
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  flush,
    input  logic           [1:0]  in_valid,
    input  issue_entry_t   [1:0]  in_inst,
    output logic                  in_ready,
    output logic           [1:0]  head_valid,
    output bypass_issue_t  [1:0]  head_issue,
    input  bypass_output_t [1:0]  byp_in,
    input  logic                  ex_stall,
    output logic           [1:0]  out_valid,
    output issue_entry_t   [1:0]  out_inst,
    output word_t          [1:0]  out_fwd
);

    localparam int             PTR_W   = $clog2(DEPTH);
    localparam logic [PTR_W:0] DEPTH_C = (PTR_W+1)'(DEPTH);
    localparam logic [PTR_W:0] TWO_C   = (PTR_W+1)'(2);

    issue_entry_t       r_mem [DEPTH];
    logic [PTR_W-1:0]   r_head;
    logic [PTR_W-1:0]   r_tail;
    logic [PTR_W:0]     r_count;
    logic [1:0]         r_out_valid;
    issue_entry_t [1:0] r_out_inst;
    word_t [1:0]        r_out_fwd;

    logic [PTR_W-1:0]   w_head1;
    logic [PTR_W-1:0]   w_tail1;
    issue_entry_t       w_h0;
    issue_entry_t       w_h1;
    logic               w_push;
    logic [PTR_W:0]     w_push_n;
    logic [PTR_W:0]     w_pop_n;
    logic               w_pair_ok;
    logic               w_iss0;
    logic               w_iss1;

    assign w_head1 = r_head + 1'b1;
    assign w_tail1 = r_tail + 1'b1;

    // admission looks only at the start-of-cycle occupancy, never at same-cycle pops
    assign in_ready = (DEPTH_C - r_count) >= TWO_C;
    assign w_push   = in_ready & in_valid[0];
    assign w_push_n = !w_push     ? '0 :
                      in_valid[1] ? TWO_C : (PTR_W+1)'(1);

    assign head_valid[0] = (r_count != '0);
    assign head_valid[1] = (r_count >= TWO_C);

    assign w_h0 = r_mem[r_head];
    assign w_h1 = r_mem[w_head1];

    assign head_issue[0] = head_valid[0] ? to_bypass(w_h0) : '0;
    assign head_issue[1] = head_valid[1] ? to_bypass(w_h1) : '0;

    issue_pair_check u_pair_check (
        .i_slot0   (w_h0),
        .i_slot1   (w_h1),
        .o_pair_ok (w_pair_ok)
    );

    assign w_iss0  = head_valid[0] & byp_in[0].valid & ~ex_stall & ~flush;
    assign w_iss1  = w_iss0 & head_valid[1] & byp_in[1].valid & w_pair_ok;
    assign w_pop_n = {{PTR_W{1'b0}}, w_iss0} + {{PTR_W{1'b0}}, w_iss1};

    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_tail] <= in_inst[0];
            if (in_valid[1]) begin
                r_mem[w_tail1] <= in_inst[1];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + w_pop_n[PTR_W-1:0];
            r_tail  <= r_tail + w_push_n[PTR_W-1:0];
            r_count <= r_count + w_push_n - w_pop_n;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_out_valid <= '0;
            r_out_inst  <= '0;
            r_out_fwd   <= '0;
        end else if (flush) begin
            r_out_valid <= '0;
        end else if (!ex_stall) begin
            r_out_valid   <= {w_iss1, w_iss0};
            r_out_inst[0] <= w_iss0 ? w_h0 : '0;
            r_out_inst[1] <= w_iss1 ? w_h1 : '0;
            r_out_fwd[0]  <= w_iss0 ? byp_in[0].fwd : '0;
            r_out_fwd[1]  <= w_iss1 ? byp_in[1].fwd : '0;
        end
    end

    assign out_valid = r_out_valid;
    assign out_inst  = r_out_inst;
    assign out_fwd   = r_out_fwd;

endmodule
